// File: rtl/stream_to_bram_capture_pkg.sv
// stream_to_bram_capture_pkg: frame geometry, capture state encoding and sample formatting shared with the stream source
package stream_to_bram_capture_pkg;
    localparam int FILTER_SIZE               = 16;
    localparam int NUMBER_OF_REAL_IMAG_WORDS = 1024;
    localparam int FRAME_BEATS               = NUMBER_OF_REAL_IMAG_WORDS + FILTER_SIZE;
    localparam int CTR_BITS                  = 11;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } capture_state_t;
    function automatic logic [63:0] format_sample(input logic [47:0] d);
        return {{8{d[47]}}, d[47:24], {8{d[23]}}, d[23:0]};
    endfunction
endpackage

// File: rtl/stream_to_bram_capture_axis_frame_tracker.sv
// axis_frame_tracker: beat counter and sync flag that follow TLAST framing and flag violations
module axis_frame_tracker
    import stream_to_bram_capture_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_beat,
    input  logic                i_last,
    output logic [CTR_BITS-1:0] o_ctr,
    output logic                o_synced,
    output logic                o_err_now,
    output logic                o_frame_error
);
    logic [CTR_BITS-1:0] r_ctr;
    logic                r_synced;
    logic                r_frame_error;
    logic                w_end;
    assign w_end     = r_ctr == CTR_BITS'(FRAME_BEATS - 1);
    assign o_err_now = i_beat & r_synced & (i_last ? !w_end : w_end);
    // TLAST always resyncs; a missing TLAST at the frame end drops sync
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctr         <= '0;
            r_synced      <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= o_err_now;
            if (i_beat) begin
                if (i_last) begin
                    r_ctr    <= '0;
                    r_synced <= 1'b1;
                end else if (w_end && r_synced) begin
                    r_ctr    <= '0;
                    r_synced <= 1'b0;
                end else begin
                    r_ctr <= r_ctr + 1'b1;
                end
            end
        end
    end
    assign o_ctr         = r_ctr;
    assign o_synced      = r_synced;
    assign o_frame_error = r_frame_error;
endmodule

// File: rtl/stream_to_bram_capture.sv
// stream_to_bram_capture: captures one aligned frame of stream samples into BRAM on software arm
module stream_to_bram_capture
    import stream_to_bram_capture_pkg::*;
#(
    parameter int BRAM_DEPTH_BITS      = 10,
    parameter int C_S_AXIS_TDATA_WIDTH = 48,
    parameter int BRAM_TDATA_WIDTH     = 64
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            S_AXIS_ARESET,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [5:0]                      S_AXIS_TSTRB,
    input  logic                            S_AXIS_TVALID,
    input  logic                            S_AXIS_TLAST,
    output logic                            S_AXIS_TREADY,
    output logic [BRAM_DEPTH_BITS-1:0]      BRAM_ADDR,
    output logic [BRAM_TDATA_WIDTH-1:0]     BRAM_DATAOUT,
    output logic                            BRAM_WE,
    input  logic                            CAPTURE_ARM,
    output logic                            CAPTURE_BUSY,
    output logic                            CAPTURE_DONE,
    output logic                            FRAME_ERROR
);
    capture_state_t              r_state;
    capture_state_t              w_next;
    logic                        r_tready;
    logic                        r_we;
    logic [BRAM_DEPTH_BITS-1:0]  r_addr;
    logic [BRAM_TDATA_WIDTH-1:0] r_data;
    logic                        r_done;
    logic                        w_beat;
    logic                        w_wr;
    logic [CTR_BITS-1:0]         w_ctr;
    logic                        w_synced;
    logic                        w_err_now;
    logic                        w_sample;
    logic                        w_unused_tstrb;
    assign w_unused_tstrb = &S_AXIS_TSTRB;
    assign w_beat         = S_AXIS_TVALID & r_tready;
    assign w_sample       = w_ctr < CTR_BITS'(NUMBER_OF_REAL_IMAG_WORDS);
    axis_frame_tracker u_tracker (
        .clk           (S_AXIS_ACLK),
        .rst           (S_AXIS_ARESET),
        .i_beat        (w_beat),
        .i_last        (S_AXIS_TLAST),
        .o_ctr         (w_ctr),
        .o_synced      (w_synced),
        .o_err_now     (w_err_now),
        .o_frame_error (FRAME_ERROR)
    );
    // Capture sequencing: wait for an aligned frame start, write its samples, abort on framing error
    always_comb begin
        w_next = r_state;
        w_wr   = 1'b0;
        case (r_state)
            ST_IDLE: w_next = CAPTURE_ARM ? ST_ARMED : ST_IDLE;
            ST_ARMED: begin
                if (w_beat && w_synced && w_ctr == '0 && !w_err_now) begin
                    w_wr   = 1'b1;
                    w_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_err_now) begin
                    w_next = ST_ARMED;
                end else if (w_beat && w_sample) begin
                    w_wr   = 1'b1;
                    w_next = (w_ctr == CTR_BITS'(NUMBER_OF_REAL_IMAG_WORDS - 1)) ? ST_DONE : ST_CAPTURE;
                end
            end
            default: w_next = CAPTURE_ARM ? ST_ARMED : ST_DONE;
        endcase
    end
    // State, ready and registered BRAM write port; DONE lags the final write by one cycle
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_state  <= ST_IDLE;
            r_tready <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_tready <= 1'b1;
            r_we     <= w_wr;
            r_done   <= (r_state == ST_DONE) & !CAPTURE_ARM;
            if (w_wr) begin
                r_addr <= w_ctr[BRAM_DEPTH_BITS-1:0];
                r_data <= format_sample(S_AXIS_TDATA);
            end
        end
    end
    assign S_AXIS_TREADY = r_tready;
    assign BRAM_WE       = r_we;
    assign BRAM_ADDR     = r_addr;
    assign BRAM_DATAOUT  = r_data;
    assign CAPTURE_BUSY  = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
    assign CAPTURE_DONE  = r_done;
endmodule

// File: tb/tb_stream_to_bram_capture.sv
// tb_stream_to_bram_capture: directed frame scenarios checked against a shadow BRAM built from observed writes
module tb_stream_to_bram_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] S_AXIS_TDATA = '0;
    logic [5:0]  S_AXIS_TSTRB = '1;
    logic        S_AXIS_TVALID = 1'b0;
    logic        S_AXIS_TLAST = 1'b0;
    logic        S_AXIS_TREADY;
    logic [9:0]  BRAM_ADDR;
    logic [63:0] BRAM_DATAOUT;
    logic        BRAM_WE;
    logic        CAPTURE_ARM = 1'b0;
    logic        CAPTURE_BUSY;
    logic        CAPTURE_DONE;
    logic        FRAME_ERROR;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int err_count = 0;
    int cyc = 0;
    int w1023_cyc = -1;
    int done_rise = -1;
    bit done_prev = 1'b0;
    int w0, e0, bad;
    logic [63:0] mem [0:1023];

    stream_to_bram_capture dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TSTRB  (S_AXIS_TSTRB),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .BRAM_ADDR     (BRAM_ADDR),
        .BRAM_DATAOUT  (BRAM_DATAOUT),
        .BRAM_WE       (BRAM_WE),
        .CAPTURE_ARM   (CAPTURE_ARM),
        .CAPTURE_BUSY  (CAPTURE_BUSY),
        .CAPTURE_DONE  (CAPTURE_DONE),
        .FRAME_ERROR   (FRAME_ERROR)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Shadow BRAM, write counter, error-pulse counter and DONE rise time
    always @(negedge clk) begin
        if (BRAM_WE) begin
            mem[BRAM_ADDR] = BRAM_DATAOUT;
            wr_count++;
            if (BRAM_ADDR == 10'd1023) w1023_cyc = cyc;
        end
        if (FRAME_ERROR) err_count++;
        if (CAPTURE_DONE && !done_prev) done_rise = cyc;
        done_prev = CAPTURE_DONE;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] sample(input logic [23:0] base, input int k);
        logic [23:0] s;
        s = base + 24'(k);
        return {24'(-s), s};
    endfunction

    function automatic logic [63:0] bram_word(input logic [23:0] base, input int k);
        logic [47:0] d;
        d = sample(base, k);
        return {{8{d[47]}}, d[47:24], {8{d[23]}}, d[23:0]};
    endfunction

    function automatic int count_bad(input logic [23:0] base);
        int n = 0;
        for (int k = 0; k < 1024; k++) if (mem[k] !== bram_word(base, k)) n++;
        return n;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse();
        CAPTURE_ARM = 1'b1;
        @(posedge clk);
        #1;
        CAPTURE_ARM = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] base, input int n, input int last_at, input int gap, input bit arm_last);
        for (int k = 0; k < n; k++) begin
            while (gap > 0 && int'($urandom_range(99)) < gap) begin
                @(posedge clk);
                #1;
            end
            S_AXIS_TDATA  = (k < 1024) ? sample(base, k) : 48'd0;
            S_AXIS_TLAST  = (k == last_at);
            S_AXIS_TVALID = 1'b1;
            CAPTURE_ARM   = arm_last && (k == last_at);
            @(posedge clk);
            #1;
            S_AXIS_TVALID = 1'b0;
            S_AXIS_TLAST  = 1'b0;
            CAPTURE_ARM   = 1'b0;
        end
    endtask

    initial begin
        idle(2);
        check_eq("rst_tready", S_AXIS_TREADY, 0);
        check_eq("rst_we", BRAM_WE, 0);
        check_eq("rst_addr", BRAM_ADDR, 0);
        check_eq("rst_data", BRAM_DATAOUT, 0);
        check_eq("rst_busy", CAPTURE_BUSY, 0);
        check_eq("rst_done", CAPTURE_DONE, 0);
        check_eq("rst_ferr", FRAME_ERROR, 0);
        rst = 1'b0;
        idle(2);
        check_eq("tready_up", S_AXIS_TREADY, 1);

        arm_pulse();
        check_eq("armed_busy", CAPTURE_BUSY, 1);
        w0 = wr_count;
        send_frame(24'h0, 300, -1, 0, 0);
        send_frame(24'h0, 1, 0, 0, 0);
        idle(2);
        check_eq("unsync_nowrite", wr_count - w0, 0);
        check_eq("unsync_noerr", err_count, 0);
        send_frame(24'h0, 1040, 1039, 0, 0);
        idle(2);
        check_eq("f1_writes", wr_count - w0, 1024);
        check_eq("f1_done", CAPTURE_DONE, 1);
        check_eq("f1_busy", CAPTURE_BUSY, 0);
        check_eq("f1_addr0", mem[0], 64'h0);
        check_eq("f1_addr5", mem[5], 64'hFFFFFFFB_00000005);
        check_eq("f1_addr1023", mem[1023], 64'hFFFFFC01_000003FF);
        check_eq("f1_contents_bad", count_bad(24'h0), 0);
        check_eq("f1_done_lag", done_rise - w1023_cyc, 1);

        w0 = wr_count;
        send_frame(24'h1000, 1040, 1039, 0, 0);
        send_frame(24'h2000, 1040, 1039, 0, 0);
        idle(2);
        check_eq("f23_nowrite", wr_count - w0, 0);
        check_eq("f23_addr5", mem[5], 64'hFFFFFFFB_00000005);
        check_eq("f23_done", CAPTURE_DONE, 1);
        check_eq("f23_noerr", err_count, 0);

        e0 = err_count;
        arm_pulse();
        check_eq("rearm_done_clr", CAPTURE_DONE, 0);
        check_eq("rearm_busy", CAPTURE_BUSY, 1);
        send_frame(24'h3000, 501, 500, 0, 0);
        idle(2);
        check_eq("early_err", err_count - e0, 1);
        check_eq("early_busy", CAPTURE_BUSY, 1);
        check_eq("early_done", CAPTURE_DONE, 0);
        w0 = wr_count;
        send_frame(24'h4000, 1040, 1039, 0, 0);
        idle(2);
        check_eq("recap_writes", wr_count - w0, 1024);
        check_eq("recap_addr0", mem[0], 64'hFFFFC000_00004000);
        check_eq("recap_contents_bad", count_bad(24'h4000), 0);
        check_eq("recap_done", CAPTURE_DONE, 1);

        e0 = err_count;
        send_frame(24'h5000, 1040, -1, 0, 0);
        idle(2);
        check_eq("miss_err", err_count - e0, 1);
        arm_pulse();
        w0 = wr_count;
        send_frame(24'h6000, 1040, 1039, 0, 0);
        idle(2);
        check_eq("desync_nowrite", wr_count - w0, 0);
        check_eq("desync_noerr", err_count - e0, 1);
        check_eq("desync_busy", CAPTURE_BUSY, 1);
        w0 = wr_count;
        send_frame(24'h7000, 1040, 1039, 30, 0);
        idle(2);
        check_eq("gap_writes", wr_count - w0, 1024);
        check_eq("gap_contents_bad", count_bad(24'h7000), 0);
        check_eq("gap_done", CAPTURE_DONE, 1);

        send_frame(24'h8000, 1040, 1039, 0, 1);
        check_eq("armlast_busy", CAPTURE_BUSY, 1);
        check_eq("armlast_done", CAPTURE_DONE, 0);
        w0 = wr_count;
        send_frame(24'h9000, 700, -1, 0, 0);
        idle(1);
        check_eq("armlast_writes", wr_count - w0, 700);
        check_eq("armlast_addr0", mem[0], bram_word(24'h9000, 0));
        check_eq("armlast_addr699", mem[699], bram_word(24'h9000, 699));
        check_eq("midcap_busy", CAPTURE_BUSY, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_we", BRAM_WE, 0);
        check_eq("arst_addr", BRAM_ADDR, 0);
        check_eq("arst_data", BRAM_DATAOUT, 0);
        check_eq("arst_busy", CAPTURE_BUSY, 0);
        check_eq("arst_tready", S_AXIS_TREADY, 0);
        check_eq("arst_done", CAPTURE_DONE, 0);
        #20 rst = 1'b0;
        idle(3);
        check_eq("post_busy", CAPTURE_BUSY, 0);
        check_eq("post_done", CAPTURE_DONE, 0);
        w0 = wr_count;
        send_frame(24'hA000, 1040, 1039, 0, 0);
        send_frame(24'hB000, 1040, 1039, 0, 0);
        idle(2);
        check_eq("post_nowrite", wr_count - w0, 0);
        check_eq("post_done2", CAPTURE_DONE, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
